// File: rtl/serial_subtractor_if.sv
// Purpose : operand/result bundle between a controller and serial_subtractor.
// Latency : none, plain signal grouping.
// Backpr. : none; start is only honoured by the subtractor while it is idle.
//
// Signals : start, a, b, bin (controller -> subtractor);
//           busy, done, diff, bout, [ovf] (subtractor -> controller).
// Macro   : SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial W-bit subtractor, diff = a - b - bin (mod 2^W), LSB first.
// Latency : start accepted at edge 0 -> done pulses for one cycle after edge W.
// Backpr. : start is ignored while busy or during the done cycle.
//
// Ports   : clk, rst (async, active-high);
//           bus.start/a/b/bin in, bus.busy/done/diff/bout out.
// Macro   : SERIAL_SUB_OVF_EN adds bus.ovf, the signed overflow of the result.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  sa;          // minuend, consumed LSB first
    logic [W-1:0]  sb;          // subtrahend, consumed LSB first
    logic          br;          // borrow carried between bit-cycles
    logic [CW-1:0] cnt;         // index of the bit being processed
    logic [W-1:0]  diff_q;
    logic          bout_q;

    logic          accept;      // start taken this cycle
    logic          last;        // final bit-cycle of the operation
    logic          ai;
    logic          bi;
    logic          d;
    logic          bo;

    // One full-subtractor cell
    assign ai = sa[0];
    assign bi = sb[0];
    assign d  = ai ^ bi ^ br;
    assign bo = (~ai & bi) | (~(ai ^ bi) & br);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            sa     <= bus.a;
            sb     <= bus.b;
            br     <= bus.bin;
            cnt    <= '0;
            bout_q <= 1'b0;
        end else if (state == SHIFT) begin
            // Result bits enter at the MSB so that after W shifts bit 0
            // has reached position 0.
            diff_q <= {d, diff_q[W-1:1]};
            sa     <= {1'b0, sa[W-1:1]};
            sb     <= {1'b0, sb[W-1:1]};
            br     <= bo;
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout_q <= bo;
            end
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    // The shift registers are consumed during the operation, so the operand
    // sign bits are kept separately for the overflow decision.
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[W-1];
            b_msb <= bus.b[W-1];
            ovf_q <= 1'b0;
        end else if (last) begin
            // d is the result sign bit on the final bit-cycle
            ovf_q <= (a_msb != b_msb) && (d != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : scoreboard bench for serial_subtractor (W=8), directed vectors.
// Latency : checks done at cycle W+1 after accept and busy for W cycles.
// Backpr. : exercises start hammering while busy and reset mid-operation.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_if #(.W(W)) bus();

    serial_subtractor #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    // {ovf, bout, diff}
    logic [W+1:0] sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            logic [W+1:0] e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("diff", int'(bus.diff), int'(e[W-1:0]));
                check("bout", int'(bus.bout), int'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", int'(bus.ovf), int'(e[W+1]));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ed,
                          input logic eb, input logic eo);
        int cyc;
        int busy_cyc;
        bit got;
        sb_q.push_back({eo, eb, ed});
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        bus.bin   = tbin;
        @(posedge clk); #1;            // accept edge
        bus.start = 1'b0;
        cyc = 0; busy_cyc = 0; got = 0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.done === 1'b1) got = 1;
        end
        check("done_latency", cyc, W + 1);
        check("busy_cycles", busy_cyc, W);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int cyc;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_bout", int'(bus.bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", int'(bus.ovf), 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_diff", int'(bus.diff), 8'hFE);
        check("hold_bout", int'(bus.bout), 1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // start held high with changing operands while busy
        base = done_cnt;
        sb_q.push_back({1'b0, 1'b0, 8'h0C});
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h04;
        bus.bin   = 1'b0;
        cyc = 0;
        while (done_cnt == base && cyc < 40) begin
            @(posedge clk); #1;
            bus.a   = bus.a + 8'h11;
            bus.b   = bus.b + 8'h07;
            bus.bin = ~bus.bin;
            cyc++;
        end
        bus.start = 1'b0;
        repeat (2 * W) @(negedge clk);
        check("hammer_single_done", done_cnt - base, 1);
        check("hammer_idle", int'(bus.busy), 0);

        // reset during bit-cycle 4: abort with no done pulse
        base = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h22;
        bus.bin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_bout", int'(bus.bout), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);
        run_op(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
